// File: rtl/ysyx_22050133_fetch_queue.sv
// ysyx_22050133_fetch_queue: single-outstanding instruction fetcher feeding a circular {pc, inst} queue to decode.
module ysyx_22050133_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int BUS_W = 64,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [BUS_W-1:0]  rsp_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst,
  input  logic              out_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;
  state_t state;
  logic [ADDR_W-1:0] fpc, tag;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic fire, push, pop;
  logic [31:0] inst;
  // DEPTH is a power of two, so the count MSB alone marks a full queue
  assign req_valid = !rst && state == REQ && !count[PW] && !redirect_valid;
  assign req_addr = fpc;
  assign fire = req_valid && req_ready;
  assign push = state == WAIT && rsp_valid && !redirect_valid;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready && !redirect_valid;
  assign inst = (BUS_W == 64 && tag[2]) ? rsp_data[BUS_W-1 -: 32] : rsp_data[31:0];
  assign out_pc = pc_q[rd_ptr];
  assign out_inst = inst_q[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REQ;
      fpc <= RESET_PC;
      tag <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      fpc <= redirect_pc & ~ADDR_W'(3);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      state <= (state != REQ && !rsp_valid) ? DROP : REQ;
    end else begin
      if (fire) begin
        tag <= fpc;
        fpc <= fpc + ADDR_W'(4);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      state <= fire ? WAIT : (state != REQ && rsp_valid) ? REQ : state;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr] <= tag;
      inst_q[wr_ptr] <= inst;
    end
  end
endmodule

// File: tb/tb_ysyx_22050133_fetch_queue.sv
// tb_ysyx_22050133_fetch_queue: random traffic against a queue-based reference of the fetcher.
module tb_ysyx_22050133_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int IDLE = 0, BUSY = 1, DROPPING = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic redirect_valid = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [63:0] rsp_data = '0;
  logic req_valid, out_valid;
  logic [31:0] req_addr, out_pc, out_inst;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
  ent_t mq[$];
  int mode = IDLE;
  logic [31:0] m_fpc = RESET_PC, m_tag = RESET_PC;
  int checks = 0, errors = 0;
  int knobs [5][4] = '{'{100, 100, 100, 0}, '{100, 100, 0, 0}, '{100, 100, 100, 0},
                       '{50, 50, 50, 6}, '{40, 60, 70, 12}};
  ysyx_22050133_fetch_queue #(.ADDR_W(32), .BUS_W(64), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .out_valid(out_valid),
    .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  // memory contents: every 32-bit word has a distinct value derived from its address
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a ^ 32'h3C5A_96E1) * 32'h0001_0003 + 32'h0000_1234;
  endfunction
  function automatic logic [63:0] line(input logic [31:0] a);
    return {word({a[31:3], 3'b100}), word({a[31:3], 3'b000})};
  endfunction
  function automatic logic chance(input int p);
    return $urandom_range(99, 0) < p;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    redirect_valid = chance(50);
    req_ready = chance(50);
    rsp_valid = chance(50);
    out_ready = chance(50);
    repeat (n) @(negedge clk);
    #1;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_req_addr", req_addr, RESET_PC);
    mode = IDLE;
    m_fpc = RESET_PC;
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic cycle(input int p_ready, input int p_rsp, input int p_out, input int p_redir);
    logic exp_rv, fire, do_pop;
    redirect_valid = chance(p_redir);
    redirect_pc = chance(50) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)));
    req_ready = chance(p_ready);
    rsp_valid = (mode != IDLE) ? chance(p_rsp) : chance(10);
    rsp_data = line(m_tag);
    out_ready = chance(p_out);
    #1;
    exp_rv = mode == IDLE && mq.size() < DEPTH && !redirect_valid;
    chk("req_valid", req_valid, exp_rv);
    chk("req_addr", req_addr, m_fpc);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_inst", out_inst, mq[0].inst);
    end
    if (redirect_valid) begin
      mq.delete();
      m_fpc = redirect_pc & ~32'd3;
      mode = (mode != IDLE && !rsp_valid) ? DROPPING : IDLE;
    end else begin
      fire = exp_rv && req_ready;
      do_pop = mq.size() != 0 && out_ready;
      if (do_pop) void'(mq.pop_front());
      if (fire) begin
        m_tag = m_fpc;
        m_fpc = m_fpc + 32'd4;
        mode = BUSY;
      end else if (mode == BUSY && rsp_valid) begin
        mq.push_back('{pc: m_tag, inst: word(m_tag)});
        mode = IDLE;
      end else if (mode == DROPPING && rsp_valid) begin
        mode = IDLE;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    do_reset(2);
    for (int p = 0; p < 5; p++) begin
      if (p == 3) do_reset(2);
      repeat (300) cycle(knobs[p][0], knobs[p][1], knobs[p][2], knobs[p][3]);
    end
    do_reset(1);
    repeat (200) cycle(60, 50, 60, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22050133_fetch_queue.md
YSYX_22050133_FETCH_QUEUE -- requirements
Module: ysyx_22050133_fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of PC and fetch addresses.
REQ-002 Parameter BUS_W, default 64, SHALL set the fetch data width; legal values 32 or 64.
REQ-003 Parameter DEPTH, default 4, SHALL set the number of instruction-queue entries; legal values: powers of 2 that are at least 2.
REQ-004 Parameter RESET_PC, default 32'h8000_0000, SHALL set the first fetch address.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-007 Port redirect_valid, input, 1 bit, SHALL request a flush and a fetch restart.
REQ-008 Port redirect_pc, input, ADDR_W bits, SHALL be the restart address, sampled when redirect_valid=1.
REQ-009 Port req_valid, output, 1 bit, SHALL indicate a fetch request to memory.
REQ-010 Port req_addr, output, ADDR_W bits, SHALL carry the fetch address.
REQ-011 Port req_ready, input, 1 bit, SHALL indicate that memory accepts the request.
REQ-012 Port rsp_valid, input, 1 bit, SHALL mark valid memory response data.
REQ-013 Port rsp_data, input, BUS_W bits, SHALL carry the memory response data.
REQ-014 Port out_valid, output, 1 bit, SHALL indicate that an instruction is presented to decode.
REQ-015 Port out_pc, output, ADDR_W bits, SHALL carry the PC of the presented instruction.
REQ-016 Port out_inst, output, 32 bits, SHALL carry the presented instruction.
REQ-017 Port out_ready, input, 1 bit, SHALL indicate that decode accepts the presented instruction.

Function
REQ-018 Block SHALL hold a fetch PC register (fpc) and a circular queue of DEPTH {pc, inst} entries with read/write pointers and a count of width clog2(DEPTH)+1.
REQ-019 FSM SHALL have three states: REQ (may issue), WAIT (one request outstanding), DROP (outstanding response to be discarded); at most one request SHALL be outstanding.
REQ-020 req_valid SHALL equal (state==REQ && count<DEPTH && !redirect_valid); req_addr SHALL equal fpc.
REQ-021 On req_valid && req_ready: latch fpc as the tag of the outstanding request; fpc <= fpc+4 (mod 2^ADDR_W, wrap-around allowed); state REQ -> WAIT.
REQ-022 While req_valid=1 and req_ready=0, req_addr SHALL remain stable.
REQ-023 In WAIT with rsp_valid=1 and redirect_valid=0: push {tag, selected instruction}; state -> REQ; the next request SHALL be issuable in the following cycle.
REQ-024 Instruction select: if BUS_W=64, take rsp_data[63:32] when tag[2]=1, else rsp_data[31:0]; if BUS_W=32, take rsp_data.
REQ-025 rsp_valid SHALL be ignored in state REQ.
REQ-026 out_valid SHALL equal (count!=0); out_pc and out_inst SHALL present the head entry; pop on out_valid && out_ready && !redirect_valid.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; a push SHALL never occur when count=DEPTH, which the issue rule of REQ-020 guarantees.
REQ-028 redirect_valid=1 (highest priority) SHALL: clear count and both pointers, so out_valid=0 from the next cycle; set fpc <= {redirect_pc[ADDR_W-1:2],2'b00}; discard any same-cycle rsp.
REQ-029 On redirect, the next state SHALL be: from REQ -> REQ; from WAIT or DROP -> DROP if rsp_valid=0, else REQ.
REQ-030 In DROP, the first rsp_valid SHALL be discarded (no push), with state -> REQ.
REQ-031 Queue order SHALL equal fetch order; no entry SHALL be lost or duplicated absent a redirect.

Reset
REQ-032 While rst=1: fpc=RESET_PC, state=REQ, count=0, pointers=0, out_valid=0, req_valid=0.
REQ-033 In the first cycle after rst deasserts: req_valid=1 and req_addr=RESET_PC.
REQ-034 Reset asserted mid-transaction SHALL abandon the outstanding request; a late response arriving after reset release in state REQ SHALL be ignored per REQ-025.

Verification
REQ-035 Reset release, req_ready=1, 1-cycle response with rsp_data=64'hAAAA_BBBB_1111_2222, out_ready=1 -> out_pc=80000000 with out_inst=1111_2222, then out_pc=80000004 with out_inst=AAAA_BBBB.
REQ-036 out_ready=0, DEPTH=4, memory always responding -> exactly 4 entries queued, then req_valid=0; raise out_ready -> fetch resumes in order with no gap or duplicate PC.
REQ-037 Redirect to 80001002 while in WAIT, with the response one cycle later -> that response dropped, queue empty, next req_addr=80001000.
REQ-038 Redirect in the same cycle as rsp_valid and out_ready -> no push, no pop, next state REQ, out_valid=0 in the next cycle.
REQ-039 req_ready held 0 for 5 cycles -> req_addr constant throughout; handshake on cycle 6 -> fpc advances by 4.
REQ-040 fpc=FFFF_FFFC, request accepted -> next req_addr=0000_0000 (wrap).
